// File: rtl/uart_tx.sv
// UART serial transmit engine: start bit, 8 data bits LSB first, one or two
// stop bits, then a single-cycle data_transmitted pulse. All outputs are
// registered, so there are no combinational paths from inputs to outputs.
module uart_tx #(
  parameter int BAUD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic              load,
  input  logic [7:0]        tx_data,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        stop_bits,
  output logic              tx,
  output logic              busy,
  output logic              data_transmitted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [BAUD_W-1:0] BAUD_ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [BAUD_W-1:0] cnt, cnt_n;
  logic [BAUD_W-1:0] div_q, div_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        data_q, data_n;
  logic              two_stop, two_stop_n;
  logic              stop_idx, stop_idx_n;
  logic              armed, armed_n;
  logic              tx_n, busy_n, done_n;
  logic              bit_end;

  // Last cycle of the current serial bit; div_q is never 0, so no underflow.
  assign bit_end = (cnt == div_q - BAUD_ONE);

  // Next-state, datapath and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold its value.
    state_n    = state;
    cnt_n      = '0;
    div_n      = div_q;
    bit_idx_n  = bit_idx;
    data_n     = data_q;
    two_stop_n = two_stop;
    stop_idx_n = stop_idx;
    armed_n    = armed;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        // Re-arm only once the upstream full flag is seen low while idle, so a
        // flag that clears late does not cause a duplicate frame.
        if (!load) armed_n = 1'b1;
        if (tx_start && load && armed) begin
          state_n    = S_START;
          data_n     = tx_data;
          div_n      = (baud_div == '0) ? BAUD_ONE : baud_div;
          two_stop_n = (stop_bits == 2'b10);
          armed_n    = 1'b0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end

      S_START: begin
        cnt_n = bit_end ? '0 : cnt + BAUD_ONE;
        if (bit_end) begin
          state_n   = S_DATA;
          bit_idx_n = 3'd0;
          tx_n      = data_q[0];
        end
      end

      S_DATA: begin
        cnt_n = bit_end ? '0 : cnt + BAUD_ONE;
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n    = S_STOP;
            stop_idx_n = 1'b0;
            tx_n       = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = data_q[bit_idx + 3'd1];
          end
        end
      end

      S_STOP: begin
        cnt_n = bit_end ? '0 : cnt + BAUD_ONE;
        if (bit_end) begin
          if (two_stop && !stop_idx) begin
            stop_idx_n = 1'b1;
          end else begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end

      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset forces an idle, armed line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      div_q            <= BAUD_ONE;
      bit_idx          <= 3'd0;
      data_q           <= 8'h00;
      two_stop         <= 1'b0;
      stop_idx         <= 1'b0;
      armed            <= 1'b1;
      tx               <= 1'b1;
      busy             <= 1'b0;
      data_transmitted <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state            <= state_n;
      cnt              <= cnt_n;
      div_q            <= div_n;
      bit_idx          <= bit_idx_n;
      data_q           <= data_n;
      two_stop         <= two_stop_n;
      stop_idx         <= stop_idx_n;
      armed            <= armed_n;
      tx               <= tx_n;
      busy             <= busy_n;
      data_transmitted <= done_n;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit engine of the memory-mapped UART peripheral. It sits directly downstream of the UART register block and consumes the TX data byte, baud divisor, control start bit, stop-bit selection and TX-full flag. It drives the serial line and returns a one-cycle `data_transmitted` pulse. The register block uses that pulse to clear its full flag and raise the TX-complete interrupt.

## Interface
- `BAUD_W`, 32, width of the baud divisor input.
- `clk  input  1  system clock; all state changes on rising edge`
- `reset  input  1  asynchronous, active-low reset`
- `tx_start  input  1  control-register enable bit; a frame may start only while high`
- `load  input  1  TX-full flag; high means `tx_data` holds an unsent byte`
- `tx_data  input  8  byte to transmit`
- `baud_div  input  BAUD_W  clock cycles per serial bit`
- `stop_bits  input  2  stop-bit count: 2'b10 selects two; any other value selects one`
- `tx  output  1  serial line; idle high`
- `busy  output  1  high while a frame is on the line`
- `data_transmitted  output  1  one-cycle pulse at end of frame`

## Operation
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
  - While reset is low: `tx`=1, `busy`=0, `data_transmitted`=0, state=IDLE, all counters=0, `armed`=1.
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current bit of the latched byte, LSB first.
  - STOP: `tx`=1.
  - DONE: one cycle; `data_transmitted`=1.
- Start condition: in IDLE, `tx_start`=1 and `load`=1 and `armed`=1.
  - On that edge the block latches `tx_data`, the effective divisor and the stop count.
  - It enters START and clears `armed`.
- Effective divisor: `baud_div`, except that 0 is treated as 1.
  - Comparison width is `BAUD_W`; no truncation.
- Baud counter:
  - Counts 0 .. div-1 within each bit.
  - On reaching div-1 it wraps to 0 and advances the bit.
- Bit sequencing:
  - START lasts one bit, then DATA.
  - DATA lasts 8 bits, using a 3-bit index 0..7; index 7 completing moves to STOP.
  - STOP lasts 1 or 2 bits per the latched count, then DONE.
  - DONE lasts one cycle, then IDLE.
- Re-arm rule:
  - `armed` is set in any cycle where the block is in IDLE and `load`=0.
  - This prevents a retransmit when the upstream full flag lags the `data_transmitted` pulse.
- Mid-frame input changes: changes to `tx_data`, `baud_div`, `stop_bits`, `tx_start` or `load` while `busy`=1 are ignored.
- `busy` is 1 in START, DATA and STOP, and 0 in IDLE and DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Start condition sampled at edge T:
  - `tx` falls and `busy` rises after edge T.
  - The first start-bit cycle is cycle T+1.
- Bit k of the frame occupies cycles T+1+k·div through T+(k+1)·div.
  - k=0 is the start bit, k=1..8 are data bits, k=9 (and k=10) are stop bits.
- Frame length is N·div cycles, where N=10 for one stop bit and N=11 for two.
- `data_transmitted` is high for exactly cycle T+1+N·div.
  - In that cycle `busy`=0 and `tx`=1.
- Earliest next start:
  - Edge sample in the cycle after DONE, and only if `armed`=1.
  - That requires `load`=0 to have been observed in IDLE first.
- Reset asserted mid-frame:
  - `tx` returns high immediately (asynchronously).
  - No `data_transmitted` pulse is issued.
  - After reset release the block is in IDLE with `armed`=1.
- `tx_start`=1 with `load`=0: stays IDLE indefinitely; no pulse.

## Test plan
- Reset check:
  - Stimulus: assert reset with random inputs.
  - Required: `tx`=1, `busy`=0, `data_transmitted`=0; release reset with `load`=0 and nothing toggles.
- Single frame, one stop bit:
  - Stimulus: `baud_div`=4, `tx_data`=0xA5, `stop_bits`=01; pulse `load` high.
  - Required: `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Required: `data_transmitted` high exactly 41 cycles after the start edge.
- Two stop bits, divisor change ignored:
  - Stimulus: `baud_div`=2, `tx_data`=0x3C, `stop_bits`=10; change `baud_div` to 9 mid-frame.
  - Required: 22-cycle frame with `tx` = 0,0,0,1,1,1,1,0,0,1,1.
  - Required: pulse at cycle 23.
- Re-arm:
  - Stimulus: hold `load`=1 through and after `data_transmitted`.
  - Required: no second frame.
  - Stimulus: drop `load` for 1 cycle, then raise it.
  - Required: a new frame starts on the following edge.
- Divisor 0:
  - Stimulus: `baud_div`=0, `tx_data`=0xFF.
  - Required: 10-cycle frame `tx` = 0 then nine 1s; pulse at cycle 11.
- Reset mid-frame:
  - Stimulus: assert reset during data bit 3.
  - Required: `tx`=1 immediately, no pulse ever.
  - Stimulus: release reset, then `load`=1.
  - Required: a fresh full frame.
